alu_ext: RTL

ALU_EXT -- requirements
Module: alu_ext

---
 rtl/alu_ext_if.sv | 29 ++
 rtl/alu_ext.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ext_if.sv
// rtl/alu_ext_if.sv - request/result bundle between an ALU client and alu_ext
//
// Request side : in_valid/in_ready handshake carrying in_op, in_a, in_b.
// Result side  : out_valid pulse with out_result, out_rem, out_overflow, out_divzero.
// master = client driving requests, slave = alu_ext.
interface alu_ext_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_rem;
    logic              out_overflow;
    logic              out_divzero;

    modport master (
        output in_valid, in_op, in_a, in_b,
        input  in_ready, out_valid, out_result, out_rem, out_overflow, out_divzero
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b,
        output in_ready, out_valid, out_result, out_rem, out_overflow, out_divzero
    );
endinterface

// File: rtl/alu_ext.sv
// rtl/alu_ext.sv - single-cycle ALU with an iterative restoring divider
//
// Ports:
//   clk     - rising-edge clock
//   resetn  - asynchronous active-low reset
//   flush   - synchronous abort of any in-flight divide; blocks accept that cycle
//   bus     - alu_ext_if.slave: in_valid/in_ready/in_op/in_a/in_b request,
//             out_valid/out_result/out_rem/out_overflow/out_divzero result
//
// Single-cycle ops return one cycle after accept. A divide with a non-zero
// divisor spends DATA_W cycles in DIV (one quotient bit each), one in FIX
// for sign correction, and its result appears the cycle after FIX.
module alu_ext #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      flush,
    alu_ext_if.slave  bus
);
    localparam int MSB   = DATA_W - 1;
    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDU = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBU = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_NOR  = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8;
    localparam logic [4:0] OP_SRL  = 5'd9;
    localparam logic [4:0] OP_SRA  = 5'd10;
    localparam logic [4:0] OP_SLT  = 5'd11;
    localparam logic [4:0] OP_SLTU = 5'd12;
    localparam logic [4:0] OP_CLZ  = 5'd13;
    localparam logic [4:0] OP_CLO  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_DIVU = 5'd16;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  quo_q, quo_d;     // dividend shifts out, quotient shifts in
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0]  dvs_q, dvs_d;     // divisor magnitude
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_result_q, out_result_d;
    logic [DATA_W-1:0]  out_rem_q, out_rem_d;
    logic               out_overflow_q, out_overflow_d;
    logic               out_divzero_q, out_divzero_d;

    logic accept;
    logic is_div;
    logic b_zero;

    assign bus.in_ready     = (state_q == S_IDLE) && !flush;
    assign accept           = bus.in_valid && bus.in_ready;
    assign is_div           = (bus.in_op == OP_DIV) || (bus.in_op == OP_DIVU);
    assign b_zero           = (bus.in_b == '0);

    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_rem      = out_rem_q;
    assign bus.out_overflow = out_overflow_q;
    assign bus.out_divzero  = out_divzero_q;

    // Single-cycle ALU, evaluated directly on the request operands.
    logic [DATA_W-1:0]  sum, diff, alu_res;
    logic               alu_ovf;
    logic [SHAMT_W-1:0] shamt;
    logic [CNT_W-1:0]   clz_cnt, clo_cnt;

    assign sum   = bus.in_a + bus.in_b;
    assign diff  = bus.in_a - bus.in_b;
    assign shamt = bus.in_a[SHAMT_W-1:0];

    // Last write wins, so the highest set (or clear) bit determines the count.
    always_comb begin
        clz_cnt = CNT_W'(DATA_W);
        clo_cnt = CNT_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (bus.in_a[i])  clz_cnt = CNT_W'(MSB - i);
            if (!bus.in_a[i]) clo_cnt = CNT_W'(MSB - i);
        end
    end

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.in_op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.in_a[MSB] == bus.in_b[MSB]) && (sum[MSB] != bus.in_a[MSB]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.in_a[MSB] != bus.in_b[MSB]) && (diff[MSB] != bus.in_a[MSB]);
            end
            OP_SUBU: alu_res = diff;
            OP_AND:  alu_res = bus.in_a & bus.in_b;
            OP_OR:   alu_res = bus.in_a | bus.in_b;
            OP_XOR:  alu_res = bus.in_a ^ bus.in_b;
            OP_NOR:  alu_res = ~(bus.in_a | bus.in_b);
            OP_SLL:  alu_res = bus.in_b << shamt;
            OP_SRL:  alu_res = bus.in_b >> shamt;
            OP_SRA:  alu_res = $signed(bus.in_b) >>> shamt;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (bus.in_a < bus.in_b)};
            OP_CLZ:  alu_res = DATA_W'(clz_cnt);
            OP_CLO:  alu_res = DATA_W'(clo_cnt);
            default: alu_res = '0;
        endcase
    end

    // Divide setup: signed divide works on magnitudes, signs fixed up in FIX.
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    assign a_neg = (bus.in_op == OP_DIV) && bus.in_a[MSB];
    assign b_neg = (bus.in_op == OP_DIV) && bus.in_b[MSB];
    assign a_mag = a_neg ? (~bus.in_a + 1'b1) : bus.in_a;
    assign b_mag = b_neg ? (~bus.in_b + 1'b1) : bus.in_b;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    logic [DATA_W:0] rem_shift, rem_sub;
    logic            rem_fits;

    assign rem_shift = {rem_q, quo_q[MSB]};
    assign rem_sub   = rem_shift - {1'b0, dvs_q};
    assign rem_fits  = (rem_shift >= {1'b0, dvs_q});

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (accept && is_div && !b_zero) state_d = S_DIV;
                end
                S_DIV: begin
                    if (cnt_q == SHAMT_W'(MSB)) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_FIX:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        quo_d          = quo_q;
        rem_d          = rem_q;
        dvs_d          = dvs_q;
        q_neg_d        = q_neg_q;
        r_neg_d        = r_neg_q;
        out_valid_d    = 1'b0;
        out_result_d   = out_result_q;
        out_rem_d      = out_rem_q;
        out_overflow_d = 1'b0;
        out_divzero_d  = 1'b0;
        if (!flush) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_div && b_zero) begin
                            out_valid_d   = 1'b1;
                            out_divzero_d = 1'b1;
                            out_result_d  = '1;
                            out_rem_d     = bus.in_a;
                        end else if (is_div) begin
                            quo_d   = a_mag;
                            rem_d   = '0;
                            dvs_d   = b_mag;
                            q_neg_d = a_neg ^ b_neg;
                            r_neg_d = a_neg;
                        end else begin
                            out_valid_d    = 1'b1;
                            out_result_d   = alu_res;
                            out_rem_d      = '0;
                            out_overflow_d = alu_ovf;
                        end
                    end
                end
                S_DIV: begin
                    quo_d = {quo_q[MSB-1:0], rem_fits};
                    rem_d = rem_fits ? rem_sub[MSB:0] : rem_shift[MSB:0];
                end
                S_FIX: begin
                    // Most-negative / -1 wraps back to most-negative here, as intended.
                    out_valid_d  = 1'b1;
                    out_result_d = q_neg_q ? (~quo_q + 1'b1) : quo_q;
                    out_rem_d    = r_neg_q ? (~rem_q + 1'b1) : rem_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo_q          <= '0;
            rem_q          <= '0;
            dvs_q          <= '0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_rem_q      <= '0;
            out_overflow_q <= 1'b0;
            out_divzero_q  <= 1'b0;
        end else begin
            quo_q          <= quo_d;
            rem_q          <= rem_d;
            dvs_q          <= dvs_d;
            q_neg_q        <= q_neg_d;
            r_neg_q        <= r_neg_d;
            out_valid_q    <= out_valid_d;
            out_result_q   <= out_result_d;
            out_rem_q      <= out_rem_d;
            out_overflow_q <= out_overflow_d;
            out_divzero_q  <= out_divzero_d;
        end
    end
endmodule
